// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite responders: response codes, FSM
// states, R-channel payload and the local-read timeout counter width.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned TO_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [1:0]        resp;
    } r_payload_t;

endpackage

// File: rtl/axil_addr_decode.sv
// Combinational AXI-Lite window decode: byte address -> hit flag and word index.
// Shared by the read and write responders.
module axil_addr_decode #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned NUM_REGS  = 16
) (
    input  logic [31:0]                 i_araddr,
    output logic                        o_hit,
    output logic [$clog2(NUM_REGS)-1:0] o_index
);

    localparam int unsigned IDX_W = $clog2(NUM_REGS);

    logic [31:0] w_off;
    logic [29:0] w_word;

    // Offset from the window base (wraps below base) reduced to a word number.
    always_comb begin
        w_off   = i_araddr - BASE_ADDR;
        w_word  = 30'(w_off >> 2);
        o_hit   = (i_araddr[1:0] == 2'b00) && (w_word < 30'(NUM_REGS));
        o_index = w_word[IDX_W-1:0];
    end

endmodule

// File: rtl/axi_lite_read_responder.sv
// AXI4-Lite read responder: accepts one AR at a time, reads a word through a
// variable-latency local register port and returns it on R.
// Optional macro AXIL_RD_TIMEOUT_EN: abort a stalled local read after TIMEOUT
// cycles with SLVERR.
module axi_lite_read_responder
    import axi_lite_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned NUM_REGS  = 16,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                        ACLK,
    input  logic                        ARESETn,
    input  logic                        ARVALID,
    output logic                        ARREADY,
    input  logic [31:0]                 ARADDR,
    input  logic [2:0]                  ARPROT,
    output logic                        RVALID,
    input  logic                        RREADY,
    output logic [31:0]                 RDATA,
    output logic [1:0]                  RRESP,
    output logic                        Rd_Req,
    output logic [$clog2(NUM_REGS)-1:0] Rd_Addr,
    output logic [2:0]                  Rd_Prot,
    input  logic                        Rd_Ack,
    input  logic [31:0]                 Rd_Data,
    input  logic                        Rd_Err
);

    localparam int unsigned IDX_W = $clog2(NUM_REGS);

    state_t           r_state, w_state_nxt;
    logic             r_arready, w_arready_nxt;
    logic             r_rvalid, w_rvalid_nxt;
    r_payload_t       r_rpl, w_rpl_nxt;
    logic             r_rd_req, w_rd_req_nxt;
    logic [IDX_W-1:0] r_rd_addr, w_rd_addr_nxt;
    logic [2:0]       r_rd_prot, w_rd_prot_nxt;

    logic             w_hit;
    logic [IDX_W-1:0] w_index;

`ifdef AXIL_RD_TIMEOUT_EN
    logic [TO_CNT_W-1:0] r_to_cnt, w_to_cnt_nxt, w_to_cnt_inc;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^TO_CNT_W'(TIMEOUT);
`endif

    axil_addr_decode #(
        .BASE_ADDR (BASE_ADDR),
        .NUM_REGS  (NUM_REGS)
    ) u_decode (
        .i_araddr (ARADDR),
        .o_hit    (w_hit),
        .o_index  (w_index)
    );

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        w_state_nxt   = r_state;
        w_arready_nxt = r_arready;
        w_rvalid_nxt  = r_rvalid;
        w_rpl_nxt     = r_rpl;
        w_rd_req_nxt  = r_rd_req;
        w_rd_addr_nxt = r_rd_addr;
        w_rd_prot_nxt = r_rd_prot;
`ifdef AXIL_RD_TIMEOUT_EN
        w_to_cnt_inc  = TO_CNT_W'(r_to_cnt + 1'b1);
        w_to_cnt_nxt  = r_to_cnt;
`endif
        case (r_state)
            ST_IDLE: begin
                w_arready_nxt = 1'b1;
                if (ARVALID && r_arready) begin
                    w_arready_nxt = 1'b0;
                    w_rd_prot_nxt = ARPROT;
                    if (w_hit) begin
                        w_rd_addr_nxt = w_index;
                        w_rd_req_nxt  = 1'b1;
                        w_state_nxt   = ST_REQ;
`ifdef AXIL_RD_TIMEOUT_EN
                        w_to_cnt_nxt  = '0;
`endif
                    end else begin
                        w_rpl_nxt.data = '0;
                        w_rpl_nxt.resp = RESP_SLVERR;
                        w_rvalid_nxt   = 1'b1;
                        w_state_nxt    = ST_RESP;
                    end
                end
            end
            ST_REQ: begin
                if (Rd_Ack) begin
                    w_rd_req_nxt   = 1'b0;
                    w_rpl_nxt.data = Rd_Data;
                    w_rpl_nxt.resp = Rd_Err ? RESP_SLVERR : RESP_OKAY;
                    w_rvalid_nxt   = 1'b1;
                    w_state_nxt    = ST_RESP;
                end
`ifdef AXIL_RD_TIMEOUT_EN
                else if (w_to_cnt_inc == TO_CNT_W'(TIMEOUT)) begin
                    w_rd_req_nxt   = 1'b0;
                    w_rpl_nxt.data = '0;
                    w_rpl_nxt.resp = RESP_SLVERR;
                    w_rvalid_nxt   = 1'b1;
                    w_state_nxt    = ST_RESP;
                end else begin
                    w_to_cnt_nxt   = w_to_cnt_inc;
                end
`endif
            end
            ST_RESP: begin
                if (RREADY) begin
                    w_rvalid_nxt  = 1'b0;
                    w_arready_nxt = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_arready_nxt = 1'b0;
                w_rvalid_nxt  = 1'b0;
                w_rd_req_nxt  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state   <= ST_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rpl     <= '0;
            r_rd_req  <= 1'b0;
            r_rd_addr <= '0;
            r_rd_prot <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_arready <= w_arready_nxt;
            r_rvalid  <= w_rvalid_nxt;
            r_rpl     <= w_rpl_nxt;
            r_rd_req  <= w_rd_req_nxt;
            r_rd_addr <= w_rd_addr_nxt;
            r_rd_prot <= w_rd_prot_nxt;
        end
    end

`ifdef AXIL_RD_TIMEOUT_EN
    // Cycles spent waiting for the local ack in the current request.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= w_to_cnt_nxt;
        end
    end
`endif

    assign ARREADY = r_arready;
    assign RVALID  = r_rvalid;
    assign RDATA   = r_rpl.data;
    assign RRESP   = r_rpl.resp;
    assign Rd_Req  = r_rd_req;
    assign Rd_Addr = r_rd_addr;
    assign Rd_Prot = r_rd_prot;

endmodule
